io_bus_responder: RTL
=====================

# io_bus_responder

Memory-mapped I/O responder on the far end of the CPU's `io_bus`. The CPU drives `io_addr`, `io_dout` and `io_we`, and this block returns `io_din`. It owns the board-side peripherals: LEDs, a debounced switch-input channel with a valid/overrun handshake, a rate-limited seven-segment data register, and a free-running cycle counter. Reads are combinational in the same cycle. Writes commit on the clock edge.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles required before the debounced button level changes. Must be ≥ 1.
- SEG_HOLD, default 4: number of cycles `seg_rdy` stays low after an accepted SEG_DATA write. Must be ≥ 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- io_addr  in  32  byte address from the CPU. Selected when io_addr[10]=1; io_addr[7:2] is the word offset; all other bits are ignored.
- io_dout  in  32  write data from the CPU.
- io_we  in  1  write strobe; qualified by io_addr[10].
- io_din  out  32  read data; combinational from io_addr.
- sw  in  8  board switches (asynchronous).
- button  in  1  board push-button (asynchronous, bouncing).
- led  out  8  LED register.
- seg_data  out  32  seven-segment display value.
- seg_rdy  out  1  display register ready to accept a new value.

## Operation
Register map (offsets relative to 0x400):
- 0x00 LED: R/W. Bits [7:0] drive `led`; bits [31:8] read as 0.
- 0x04 SWX_VLD: R. bit0 = vld, bit1 = ovf, other bits 0. Writing with bit0=1 clears both vld and ovf. Writing with bit0=0 has no effect.
- 0x08 SWX_DATA: R. {24'b0, switch value captured on the last accepted press}. Writes ignored.
- 0x0C SEG_RDY: R. {31'b0, seg_rdy}. Writes ignored.
- 0x10 SEG_DATA: R/W. Read returns `seg_data`. A write is accepted only when seg_rdy=1; a write while seg_rdy=0 is dropped silently.
- 0x14 CNT: R. 32-bit cycle counter; increments every cycle and wraps 0xFFFFFFFF→0. Writes ignored.
- Any other offset, or io_addr[10]=0: io_din=0 and writes have no effect.

Button path:
- 2-FF synchronizer feeds a debouncer.
- The debounce counter increments while the synchronized value differs from the debounced level, and resets to 0 whenever they match.
- On the edge where the counter equals DEBOUNCE_CYCLES-1 and the values still differ, the debounced level flips.
- On a 0→1 flip (a press), on that same edge: swx_data ← synchronized `sw` (2-FF, same stage depth as button), and vld ← 1. If vld was already 1, ovf ← 1 as well.
- 1→0 flips (releases) have no side effect.

Seg path:
- An accepted write loads `seg_data`, drives seg_rdy ← 0, and loads the hold counter with SEG_HOLD.
- While seg_rdy=0 the counter decrements each cycle; seg_rdy ← 1 on the edge where the counter reaches 0.

Simultaneous events:
- A press flip and a SWX_VLD clear write in the same cycle: the press wins. vld=1, ovf=0, and data is the new capture.

## Timing
- Reset values (asynchronous, while rst=0): led=0, swx_data=0, vld=0, ovf=0, seg_data=0, seg_rdy=1, CNT=0, debounced level=0, all internal counters and synchronizer flops 0. io_din follows io_addr as a function of this state.
- Reset asserted mid-operation aborts a pending hold or debounce immediately. After release, CNT reads 0 on the first edge and 1 on the next.
- Write latency: register value visible on io_din and the outputs one cycle after the edge that samples io_we=1.
- Read latency: 0 cycles; io_din is combinational.
- Press latency: with `button` held high, vld and swx_data are visible after the (DEBOUNCE_CYCLES+2)-th rising edge that samples button=1.
- A bounce shorter than DEBOUNCE_CYCLES cycles restarts the count and produces no flip.
- seg_rdy is low for exactly SEG_HOLD cycles after an accepted write.

## Test plan
- Reset and LED: assert rst=0 mid-run. Outputs take reset values, seg_rdy=1, CNT=0. Then write 0x400←0xA5. led=0xA5 next cycle, and a read of 0x400 returns 0x000000A5.
- Debounce (DEBOUNCE_CYCLES=4): sw=0x3C; toggle button high 2 cycles, low 1 cycle, then hold high. vld=1 only after 6 consecutive high edges; 0x408 reads 0x3C and 0x404 reads 0x1.
- Overrun and clear: with vld=1, perform a second full press with sw=0x11. 0x404 reads 0x3 and 0x408 reads 0x11. Write 0x404←1; next cycle 0x404 reads 0. Then force a press flip in the same cycle as a clear write; 0x404 reads 0x1.
- Seg handshake (SEG_HOLD=4): write 0x410←0x12345678. seg_data updates and seg_rdy=0 for exactly 4 cycles. A write of 0xDEADBEEF during the hold is dropped, and seg_data stays 0x12345678.
- Decode: write to 0x000 with io_we=1 (io_addr[10]=0) and to 0x418. No register changes, and reads of both addresses return 0.
- CNT: CNT increments by 1 each cycle. Force CNT to 0xFFFFFFFF (hierarchical deposit); the next cycle reads 0.

Source files
------------

// File: rtl/io_bus_responder_if.sv
// io_bus_responder_if
//   CPU-side I/O bus between the processor and the board peripheral responder.
//   io_addr : byte address driven by the CPU
//   io_dout : write data driven by the CPU
//   io_we   : write strobe driven by the CPU
//   io_din  : combinational read data returned by the responder
interface io_bus_responder_if;
  logic [31:0] io_addr;
  logic [31:0] io_dout;
  logic        io_we;
  logic [31:0] io_din;

  modport master (output io_addr, output io_dout, output io_we, input io_din);
  modport slave  (input io_addr, input io_dout, input io_we, output io_din);
endinterface

// File: rtl/io_bus_responder.sv
// io_bus_responder
//   Memory-mapped responder for board peripherals at 0x400: LED register,
//   debounced push-button capture of the switches (valid/overrun flags),
//   rate-limited seven-segment data register and a free-running cycle counter.
//   Reads are combinational; writes commit on the rising edge of clk.
// Ports:
//   clk      : system clock
//   rst      : asynchronous reset, active low
//   bus      : CPU I/O bus (slave side)
//   sw       : board switches (asynchronous)
//   button   : board push-button (asynchronous, bouncing)
//   led      : LED register
//   seg_data : seven-segment display value
//   seg_rdy  : seven-segment register ready for a new value
//
// Seg handshake states:
//   state      | meaning
//   SEG_READY  | seg_rdy=1, next SEG_DATA write is accepted
//   SEG_BUSY   | seg_rdy=0, hold counter running down, writes dropped
module io_bus_responder #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SEG_HOLD        = 4
) (
  input  logic                clk,
  input  logic                rst,
  io_bus_responder_if.slave   bus,
  input  logic [7:0]          sw,
  input  logic                button,
  output logic [7:0]          led,
  output logic [31:0]         seg_data,
  output logic                seg_rdy
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = $clog2(SEG_HOLD + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(SEG_HOLD);

  localparam logic [5:0] OFF_LED      = 6'h00;
  localparam logic [5:0] OFF_SWX_VLD  = 6'h01;
  localparam logic [5:0] OFF_SWX_DATA = 6'h02;
  localparam logic [5:0] OFF_SEG_RDY  = 6'h03;
  localparam logic [5:0] OFF_SEG_DATA = 6'h04;
  localparam logic [5:0] OFF_CNT      = 6'h05;

  typedef enum logic {SEG_READY, SEG_BUSY} seg_state_t;

  logic             sel;
  logic [5:0]       off;
  logic             wr_en;
  logic             wr_led;
  logic             wr_clr;
  logic             wr_seg;

  logic             btn_s1, btn_s2;
  logic [7:0]       sw_s1, sw_s2;
  logic             btn_db;
  logic [DB_W-1:0]  db_cnt;
  logic             db_flip;
  logic             press;

  logic [7:0]       swx_data;
  logic             vld, ovf;
  logic [31:0]      cnt;

  seg_state_t       seg_state, seg_state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic             seg_load;

  // Only bit 10 and the word offset take part in decode.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.io_addr[31:11], bus.io_addr[9:8], bus.io_addr[1:0]};

  assign sel    = bus.io_addr[10];
  assign off    = bus.io_addr[7:2];
  assign wr_en  = sel & bus.io_we;
  assign wr_led = wr_en && (off == OFF_LED);
  assign wr_clr = wr_en && (off == OFF_SWX_VLD) && bus.io_dout[0];
  assign wr_seg = wr_en && (off == OFF_SEG_DATA);

  // Button and switches share the same synchronizer depth so the captured
  // switch value lines up with the button that caused the press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= button;
      btn_s2 <= btn_s1;
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
    end
  end

  assign db_flip = (btn_s2 != btn_db) && (db_cnt == DB_LAST);
  assign press   = db_flip && btn_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else if (btn_s2 == btn_db) begin
      db_cnt <= '0;
    end else if (db_flip) begin
      btn_db <= btn_s2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  // A press on the same edge as a clear leaves a fresh, non-overrun capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      swx_data <= '0;
      vld      <= 1'b0;
      ovf      <= 1'b0;
    end else if (press) begin
      swx_data <= sw_s2;
      vld      <= 1'b1;
      ovf      <= wr_clr ? 1'b0 : (ovf | vld);
    end else if (wr_clr) begin
      vld <= 1'b0;
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led <= '0;
      cnt <= '0;
    end else begin
      cnt <= cnt + 32'd1;
      if (wr_led) begin
        led <= bus.io_dout[7:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_state <= SEG_READY;
      hold_cnt  <= '0;
      seg_data  <= '0;
    end else begin
      seg_state <= seg_state_nxt;
      hold_cnt  <= hold_nxt;
      if (seg_load) begin
        seg_data <= bus.io_dout;
      end
    end
  end

  // Hold counter runs down from SEG_HOLD; ready returns on the edge it hits 0.
  always_comb begin
    seg_state_nxt = seg_state;
    hold_nxt      = hold_cnt;
    seg_load      = 1'b0;
    case (seg_state)
      SEG_READY: begin
        if (wr_seg) begin
          seg_state_nxt = SEG_BUSY;
          hold_nxt      = HOLD_LOAD;
          seg_load      = 1'b1;
        end
      end
      SEG_BUSY: begin
        hold_nxt = hold_cnt - HOLD_W'(1);
        if (hold_cnt == HOLD_W'(1)) begin
          seg_state_nxt = SEG_READY;
        end
      end
      default: begin
        seg_state_nxt = SEG_READY;
        hold_nxt      = '0;
      end
    endcase
  end

  assign seg_rdy = (seg_state == SEG_READY);

  always_comb begin
    bus.io_din = '0;
    if (sel) begin
      case (off)
        OFF_LED:      bus.io_din = {24'b0, led};
        OFF_SWX_VLD:  bus.io_din = {30'b0, ovf, vld};
        OFF_SWX_DATA: bus.io_din = {24'b0, swx_data};
        OFF_SEG_RDY:  bus.io_din = {31'b0, seg_rdy};
        OFF_SEG_DATA: bus.io_din = seg_data;
        OFF_CNT:      bus.io_din = cnt;
        default:      bus.io_din = '0;
      endcase
    end
  end

endmodule
